ctrlread_req_issuer: RTL

CTRLREAD_REQ_ISSUER -- requirements
Module: ctrlread_req_issuer

---
 rtl/definitions_pkg.sv | 24 ++
 rtl/ctrlread_burst_calc.sv | 47 ++++
 rtl/ctrlread_req_issuer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/definitions_pkg.sv
// definitions_pkg -- shared types and defaults for the control-read request issuer.
//   RequestItem_t : one entry of the control-read request FIFO (byte address + length in beats)
//   state_e       : issuer FSM states
//   DEF_MAX_BURST / DEF_MAX_OUTST : default burst size and in-flight limit
package definitions_pkg;

    localparam int REQ_ADDR_W    = 32;
    localparam int REQ_LEN_W     = 16;
    localparam int DEF_MAX_BURST = 16;
    localparam int DEF_MAX_OUTST = 8;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_LEN_W-1:0]  len;
    } RequestItem_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/ctrlread_burst_calc.sv
// ctrlread_burst_calc -- purely combinational burst sizing.
//   addr_i  : start byte address of the next burst
//   rem_i   : beats still to be issued for the current request
//   beats_o : beats in the next burst = min(rem_i, MAX_BURST)
// Build option: CTRLREAD_4K_SPLIT_EN additionally caps the burst so it never
// crosses a 4096-byte boundary. Addresses are expected to be beat-aligned.
module ctrlread_burst_calc
    import definitions_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int BEAT_BYTES = 8
) (
    input  logic [ADDR_W-1:0]              addr_i,
    input  logic [LEN_W-1:0]               rem_i,
    output logic [$clog2(MAX_BURST):0]     beats_o
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    // Wide enough for the remaining length and for a beat count up to 4096.
    localparam int CW = ((LEN_W > 13) ? LEN_W : 13) + 1;

    logic [CW-1:0] rem_w;
    logic [CW-1:0] cap;
    logic          unused_addr;

    assign unused_addr = ^addr_i;

`ifdef CTRLREAD_4K_SPLIT_EN
    localparam int BSH = $clog2(BEAT_BYTES);
    logic [CW-1:0] to4k;
`endif

    always_comb begin
        rem_w = CW'(rem_i);
        cap   = CW'(MAX_BURST);
`ifdef CTRLREAD_4K_SPLIT_EN
        // beats left before the next 4 KiB page; never 0 so the FSM always progresses
        to4k = (CW'(13'h1000) - CW'(addr_i[11:0])) >> BSH;
        if (to4k == '0) to4k = CW'(1);
        if (to4k < cap) cap = to4k;
`endif
        beats_o = BW'((rem_w < cap) ? rem_w : cap);
    end

endmodule

// File: rtl/ctrlread_req_issuer.sv
// ctrlread_req_issuer -- pops control-read requests from a FIFO and issues
// them as read-address bursts, limiting the number of bursts in flight.
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   fifo_dout      : head of request FIFO (RequestItem_t), valid the cycle after a pop
//   fifo_empty     : request FIFO empty
//   fifo_rd_en     : one-cycle pop strobe
//   ar_valid/ar_ready/ar_addr/ar_len : read-address channel, ar_len = beats-1
//   rd_done        : one pulse per completed burst
//   busy           : FSM not idle or bursts still in flight
//   outst          : bursts in flight
//   err_underflow  : sticky, rd_done seen with nothing in flight
// Build option: CTRLREAD_4K_SPLIT_EN (see ctrlread_burst_calc).
module ctrlread_req_issuer
    import definitions_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int MAX_OUTST  = DEF_MAX_OUTST,
    parameter int BEAT_BYTES = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$bits(RequestItem_t)-1:0] fifo_dout,
    input  logic                           fifo_empty,
    output logic                           fifo_rd_en,
    output logic                           ar_valid,
    input  logic                           ar_ready,
    output logic [ADDR_W-1:0]              ar_addr,
    output logic [7:0]                     ar_len,
    input  logic                           rd_done,
    output logic                           busy,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst,
    output logic                           err_underflow
);

    localparam int BW    = $clog2(MAX_BURST) + 1;
    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int BSH   = $clog2(BEAT_BYTES);
    localparam logic [OUT_W-1:0] OUTST_MAX = OUT_W'(MAX_OUTST);

    RequestItem_t      req;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;

    state_e            state_q, state_d;
    // addr_q/rem_q describe the part of the request not yet loaded onto ar
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              ar_valid_q, ar_valid_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]        ar_len_q, ar_len_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] calc_addr;
    logic [LEN_W-1:0]  calc_rem;
    logic [BW-1:0]     beats;
    logic              hs, dec, ud, can_issue, load;

    assign req      = RequestItem_t'(fifo_dout);
    assign req_addr = ADDR_W'(req.addr);
    assign req_len  = LEN_W'(req.len);

    // In FETCH the first burst is sized straight from the FIFO head so it can
    // go out the next cycle; afterwards the stored remainder is used.
    assign calc_addr = (state_q == ST_FETCH) ? req_addr : addr_q;
    assign calc_rem  = (state_q == ST_FETCH) ? req_len  : rem_q;

    ctrlread_burst_calc #(
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .MAX_BURST  (MAX_BURST),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_calc (
        .addr_i  (calc_addr),
        .rem_i   (calc_rem),
        .beats_o (beats)
    );

    assign hs  = ar_valid_q & ar_ready;
    assign ud  = rd_done & (outst_q == '0);
    assign dec = rd_done & (outst_q != '0);

    always_comb begin
        outst_d = outst_q;
        case ({hs, dec})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    // Judged on next-cycle occupancy: a completion this cycle frees a slot
    // for a burst presented next cycle.
    assign can_issue = (outst_d < OUTST_MAX);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        ar_valid_d = ar_valid_q & ~hs;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        err_d      = err_q | ud;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (req_len != '0) begin
                    state_d = ST_ISSUE;
                    addr_d  = req_addr;
                    rem_d   = req_len;
                    load    = can_issue;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if ((!ar_valid_q || hs) && (rem_q != '0) && can_issue) load = 1'b1;
                if (hs && (rem_q == '0)) state_d = fifo_empty ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (outst_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            ar_valid_d = 1'b1;
            ar_addr_d  = calc_addr;
            ar_len_d   = 8'(beats - BW'(1));
            addr_d     = calc_addr + (ADDR_W'(beats) << BSH);
            rem_d      = calc_rem - LEN_W'(beats);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            outst_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            outst_q    <= outst_d;
            err_q      <= err_d;
        end
    end

    // Combinational pop so the head is on fifo_dout during FETCH; gated by
    // rst so the strobe is low for the whole reset.
    assign fifo_rd_en    = (state_q == ST_IDLE) & ~fifo_empty & ~rst;
    assign ar_valid      = ar_valid_q;
    assign ar_addr       = ar_addr_q;
    assign ar_len        = ar_len_q;
    assign outst         = outst_q;
    assign busy          = (state_q != ST_IDLE) | (outst_q != '0);
    assign err_underflow = err_q;

endmodule
